// File: rtl/seq_detect_param_pkg.sv
// Shared definitions for the seq_detect_param serial pattern detector.
// Optional feature macro: SEQ_DET_COUNT_EN (saturating match counter).
package seq_det_pkg;

  localparam int unsigned SEQ_DET_LEN_MIN = 2;
  localparam int unsigned SEQ_DET_LEN_MAX = 16;

  // Fill-count width, able to hold 0..len.
  function automatic int unsigned fill_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Occupancy class of the history register, for debug and assertions.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PARTIAL = 2'd1,
    ARMED   = 2'd2
  } state_cls_t;

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial stream / control bundle for seq_detect_param.
// The cnt signal exists only when SEQ_DET_COUNT_EN is defined.
interface seq_detect_param_if #(
  parameter int LEN   = 3,
  parameter int CNT_W = 8
);

  logic           din;
  logic           din_vld;
  logic           overlap;
  logic           pat_ld;
  logic [LEN-1:0] pat_in;
  logic           cnt_clr;
  logic           Y;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt;
`endif

  if (LEN < 2 || CNT_W < 1) begin : g_bad_params
    $error("seq_detect_param_if: illegal LEN/CNT_W");
  end

  modport master (
    output din, din_vld, overlap, pat_ld, pat_in, cnt_clr,
    input  Y
`ifdef SEQ_DET_COUNT_EN
    , input cnt
`endif
  );

  modport slave (
    input  din, din_vld, overlap, pat_ld, pat_in, cnt_clr,
    output Y
`ifdef SEQ_DET_COUNT_EN
    , output cnt
`endif
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with
// increment yields 1. Used as the optional match counter (SEQ_DET_COUNT_EN).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear has priority but still counts a coincident increment; hold at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Moore serial pattern detector with programmable LEN-bit pattern,
// overlapping / non-overlapping modes and runtime pattern reload.
// Optional feature macro: SEQ_DET_COUNT_EN adds a saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101,
  parameter int             CNT_W   = 8
) (
  input logic              CLK,
  input logic              RST_N,
  seq_detect_param_if.slave bus
);

  localparam int unsigned   FW        = fill_width(LEN);
  localparam logic [FW-1:0] FILL_FULL = FW'(LEN);
  localparam logic [FW-1:0] FILL_LAST = FW'(LEN - 1);

  if (LEN < int'(SEQ_DET_LEN_MIN) || LEN > int'(SEQ_DET_LEN_MAX) || CNT_W < 1)
  begin : g_bad_params
    $error("seq_detect_param: LEN must be 2..16 and CNT_W >= 1");
  end

  logic [LEN-1:0] pat;
  logic [LEN-1:0] hist;
  logic [LEN-1:0] shifted;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  fill_inc;
  logic           accept;
  logic           m;
  logic           y_q;
  state_cls_t     state_cls;

  // Match decision looks at the history plus the bit arriving this cycle.
  always_comb begin
    shifted  = {hist[LEN-2:0], bus.din};
    accept   = bus.din_vld && !bus.pat_ld;
    m        = accept && (fill >= FILL_LAST) && (shifted == pat);
    fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
  end

  // Classify history occupancy.
  always_comb begin
    if (fill == '0) begin
      state_cls = IDLE;
    end else if (fill == FILL_FULL) begin
      state_cls = ARMED;
    end else begin
      state_cls = PARTIAL;
    end
  end

  // Pattern reload wins over sampling; a match rearms (overlap) or empties the history.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
      y_q  <= 1'b0;
    end else if (bus.pat_ld) begin
      pat  <= bus.pat_in;
      fill <= '0;
      y_q  <= 1'b0;
    end else if (bus.din_vld) begin
      hist <= shifted;
      if (m) begin
        fill <= bus.overlap ? FILL_FULL : '0;
      end else begin
        fill <= fill_inc;
      end
      y_q  <= m;
    end else begin
      y_q  <= 1'b0;
    end
  end

  assign bus.Y = y_q;

  // A pulse is only ever followed by a full (overlap) or empty (non-overlap) history.
  always_ff @(posedge CLK) begin
    if (RST_N && y_q) begin
      assert (state_cls != PARTIAL);
    end
  end

`ifdef SEQ_DET_COUNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (bus.cnt_clr),
    .inc   (m),
    .q     (bus.cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
`endif

  logic unused_hist_msb;
  assign unused_hist_msb = hist[LEN-1];

endmodule
